processor_trace_buffer: RTL and testbench
=========================================

// Module: processor_trace_buffer
// PURPOSE
//  Parametrised on-chip trace capture for the processor core. Samples per-cycle commit
//  info (PC, instruction, register-file write, data-memory write) plus a free-running
//  timestamp. Filters, triggers on a PC match, buffers records in a FIFO and drains them
//  over a valid/ready port to the debug/UVM side. Sits beside the core, passive.
// PARAMETERS
//  PC_W     8   program counter width
//  INST_W   16  instruction word width
//  DATA_W   16  reg/mem data width
//  RADDR_W  3   register address width
//  MADDR_W  3   data memory address width
//  TS_W     16  timestamp width
//  DEPTH    16  FIFO entries, power of 2, >=2
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       asynchronous reset, active-high
//  arm          in   1       pulse: IDLE/DONE -> ARMED
//  stop         in   1       pulse: any state -> IDLE
//  mode         in   2       filter: 00 all, 01 reg|mem writes, 10 mem only, 11 reg only
//  trig_pc      in   PC_W    trigger PC
//  cap_limit    in   16      records to capture after trigger; 0 = unlimited
//  commit_valid in   1       commit fields valid this cycle
//  pc           in   PC_W    committed PC
//  inst         in   INST_W  committed instruction
//  reg_en       in   2       reg write enable (nonzero = write)
//  reg_add      in   RADDR_W reg write address
//  reg_data     in   DATA_W  reg write data
//  mem_en       in   1       mem write enable
//  mem_add      in   MADDR_W mem write address
//  mem_data     in   DATA_W  mem write data
//  rec_valid    out  1       head record valid
//  rec_ready    in   1       consumer accepts head
//  rec_data     out  REC_W   {ts,pc,inst,reg_en,reg_add,reg_data,mem_en,mem_add,mem_data}, MSB first
//  fifo_count   out  clog2(DEPTH)+1  entries held
//  drop_cnt     out  8       records lost to full FIFO, saturating
//  state        out  2       00 IDLE, 01 ARMED, 10 RUN, 11 DONE
// BEHAVIOUR
//  - REC_W = TS_W+PC_W+INST_W+2+RADDR_W+2*DATA_W+1+MADDR_W (81 at defaults).
//  - Reset: state=IDLE, FIFO empty, rec_valid=0, rec_data=0, fifo_count=0, drop_cnt=0,
//    ts=0, capture counter=0. Reset mid-capture discards all FIFO contents.
//  - ts increments every cycle out of reset, wraps 2^TS_W-1 -> 0; record holds ts of sample cycle.
//  - qualify = commit_valid & filter(mode); filter uses reg_en!=0 and mem_en.
//  - FSM: IDLE -arm-> ARMED; ARMED -(qualify & pc==trig_pc)-> RUN, triggering record captured;
//    RUN -(cap counter reaches cap_limit, cap_limit!=0)-> DONE; DONE -arm-> ARMED;
//    stop beats arm and any trigger same cycle -> IDLE. arm ignored in ARMED/RUN.
//  - Capture counter clears on entering ARMED; +1 per qualifying record in RUN, incl. trigger
//    record and dropped records. cap_limit=1 -> only trigger record, then DONE.
//  - Push when (ARMED&trigger) or (RUN & qualify & not yet at limit). Record appears in FIFO
//    the following cycle; empty FIFO -> rec_valid high 1 cycle after push.
//  - Pop when rec_valid & rec_ready. Push accepted if count<DEPTH or pop same cycle
//    (full + push + pop: count unchanged, no drop). Full, no pop: record dropped,
//    drop_cnt+1, saturates at 255; drop_cnt clears only on reset or entering ARMED.
//  - rec_data stable while rec_valid & !rec_ready. Drain runs in every state; stop does not flush.
//  - Pointers wrap modulo DEPTH; fifo_count = DEPTH when full.
// TESTING
//  - Reset: assert rst mid-RUN with 5 entries -> state=0, fifo_count=0, rec_valid=0, ts=0 async.
//  - Trigger: arm, mode=00, trig_pc=8'h10, cap_limit=3, commits pc 0E,0F,10,11,12,13 ->
//    3 records pc 10,11,12, state=DONE; ts deltas 1.
//  - Filter: mode=10, RUN, 4 commits with mem_en on 2nd,4th only -> exactly 2 records, mem_en=1.
//  - Overflow: rec_ready=0, 20 qualifying commits, DEPTH=16 -> fifo_count=16, drop_cnt=4;
//    then drain -> 16 records in order, first 16 pcs.
//  - Full push+pop: FIFO full, rec_ready=1 and qualify same cycle -> count stays 16, drop_cnt unchanged.
//  - Stop vs arm: arm & stop same cycle from DONE -> IDLE; ts wraps FFFF->0000 in recorded stream.

Source files
------------

// File: rtl/processor_trace_buffer.sv
// processor_trace_buffer: filtered, PC-triggered commit trace capture into a drainable FIFO
module processor_trace_buffer #(
    parameter int PC_W    = 8,
    parameter int INST_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3,
    parameter int MADDR_W = 3,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 16,
    localparam int REC_W  = TS_W + PC_W + INST_W + 2 + RADDR_W + 2 * DATA_W + 1 + MADDR_W,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [15:0]        cap_limit,
    input  logic               commit_valid,
    input  logic [PC_W-1:0]    pc,
    input  logic [INST_W-1:0]  inst,
    input  logic [1:0]         reg_en,
    input  logic [RADDR_W-1:0] reg_add,
    input  logic [DATA_W-1:0]  reg_data,
    input  logic               mem_en,
    input  logic [MADDR_W-1:0] mem_add,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [REC_W-1:0]   rec_data,
    output logic [CW-1:0]      fifo_count,
    output logic [7:0]         drop_cnt,
    output logic [1:0]         state
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, RUN = 2'b10, DONE = 2'b11} state_t;
    state_t cur, nxt;
    logic [TS_W-1:0] ts;
    logic [15:0] cap_cnt;
    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic qualify, trigger, at_limit, enter_armed, push_req, push, pop;
    assign qualify = commit_valid & (mode == 2'b00 ? 1'b1 :
                                     mode == 2'b01 ? (|reg_en | mem_en) :
                                     mode == 2'b10 ? mem_en : |reg_en);
    assign trigger = qualify & (pc == trig_pc);
    assign at_limit = (cap_limit != 16'd0) & (cap_cnt >= cap_limit);
    assign rec_valid = fifo_count != '0;
    assign pop = rec_valid & rec_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign push = push_req & ((fifo_count != CW'(DEPTH)) | pop);
    assign rec_data = rec_valid ? mem[rp] : '0;
    assign state = cur;
    always_comb begin
        nxt = cur;
        enter_armed = 1'b0;
        push_req = 1'b0;
        if (stop)
            nxt = IDLE;
        else
            case (cur)
                IDLE, DONE: begin
                    nxt = arm ? ARMED : cur;
                    enter_armed = arm;
                end
                ARMED: begin
                    nxt = trigger ? RUN : cur;
                    push_req = trigger;
                end
                default: begin
                    nxt = at_limit ? DONE : cur;
                    push_req = qualify & ~at_limit;
                end
            endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= IDLE;
            ts <= '0;
            cap_cnt <= '0;
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            drop_cnt <= '0;
        end else begin
            cur <= nxt;
            ts <= ts + TS_W'(1);
            cap_cnt <= enter_armed ? '0 : cap_cnt + 16'(push_req);
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            drop_cnt <= enter_armed ? '0 : drop_cnt + 8'(push_req & ~push & (drop_cnt != 8'hFF));
        end
    end
    always_ff @(posedge clk)
        if (push)
            mem[wp] <= {ts, pc, inst, reg_en, reg_add, reg_data, mem_en, mem_add, mem_data};
endmodule

// File: tb/tb_processor_trace_buffer.sv
// tb_processor_trace_buffer: directed stimulus against a queue-based trace buffer model
module tb_processor_trace_buffer;
    localparam int DEPTH = 16;
    localparam int REC_W = 81;
    logic clk = 0, rst = 1, arm = 0, stop = 0, commit_valid = 0, mem_en = 0, rec_ready = 0;
    logic [1:0] mode = 0, reg_en = 0;
    logic [7:0] trig_pc = 0, pc = 0;
    logic [15:0] cap_limit = 0, inst = 0, reg_data = 0, mem_data = 0;
    logic [2:0] reg_add = 0, mem_add = 0;
    logic rec_valid;
    logic [REC_W-1:0] rec_data;
    logic [4:0] fifo_count;
    logic [7:0] drop_cnt;
    logic [1:0] state;
    int checks = 0, errors = 0;

    processor_trace_buffer dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode), .trig_pc(trig_pc),
        .cap_limit(cap_limit), .commit_valid(commit_valid), .pc(pc), .inst(inst),
        .reg_en(reg_en), .reg_add(reg_add), .reg_data(reg_data), .mem_en(mem_en),
        .mem_add(mem_add), .mem_data(mem_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .fifo_count(fifo_count), .drop_cnt(drop_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] f_pc(input logic [REC_W-1:0] r);
        return r[64:57];
    endfunction
    function automatic logic [15:0] f_ts(input logic [REC_W-1:0] r);
        return r[80:65];
    endfunction
    function automatic logic f_me(input logic [REC_W-1:0] r);
        return r[19];
    endfunction

    // model: states 0 idle, 1 armed, 2 run, 3 done; FIFO as a queue
    logic [REC_W-1:0] mq[$], got[$];
    int ms, mcnt, mdrop;
    logic [15:0] mts;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            ms = 0; mcnt = 0; mdrop = 0; mts = 0;
        end else begin
            bit q, want, popd;
            q = commit_valid && (mode == 0 || (mode == 1 && (reg_en != 0 || mem_en)) ||
                                 (mode == 2 && mem_en) || (mode == 3 && reg_en != 0));
            want = 0;
            popd = mq.size() > 0 && rec_ready;
            if (stop) ms = 0;
            else if ((ms == 0 || ms == 3) && arm) begin ms = 1; mcnt = 0; mdrop = 0; end
            else if (ms == 1 && q && pc == trig_pc) begin ms = 2; want = 1; mcnt = 1; end
            else if (ms == 2) begin
                if (cap_limit != 0 && mcnt >= int'(cap_limit)) ms = 3;
                else if (q) begin want = 1; mcnt++; end
            end
            if (popd) void'(mq.pop_front());
            if (want) begin
                if (mq.size() < DEPTH)
                    mq.push_back({mts, pc, inst, reg_en, reg_add, reg_data, mem_en, mem_add, mem_data});
                else if (mdrop < 255) mdrop++;
            end
            mts++;
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("state", state, ms);
        chk("count", fifo_count, mq.size());
        chk("valid", rec_valid, mq.size() > 0);
        chk("drop", drop_cnt, mdrop);
        chk("data", rec_data, mq.size() > 0 ? mq[0] : '0);
        if (rec_valid && rec_ready) got.push_back(rec_data);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic pulse_arm();
        arm = 1; tick(); arm = 0;
    endtask
    task automatic do_stop();
        stop = 1; tick(); stop = 0;
    endtask
    task automatic commit(input logic [7:0] p, input logic [1:0] re, input logic me);
        commit_valid = 1; pc = p; inst = {p, ~p}; reg_en = re; reg_add = p[2:0];
        reg_data = {8'h5A, p}; mem_en = me; mem_add = ~p[2:0]; mem_data = {p, 8'hC3};
        tick();
        commit_valid = 0; reg_en = 0; mem_en = 0;
    endtask
    task automatic drain();
        int n = 0;
        rec_ready = 1;
        while (fifo_count != 0 && n < 64) begin tick(); n++; end
        chk("drain_done", fifo_count, 0);
        rec_ready = 0;
    endtask

    initial begin
        int n;
        @(posedge clk); #2;
        chk("rst_state", state, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", rec_valid, 0);
        chk("rst_data", rec_data, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #2 rst = 0;

        trig_pc = 8'h10; cap_limit = 3; mode = 0;
        pulse_arm();
        for (int i = 0; i < 6; i++) commit(8'h0E + 8'(i), 0, 0);
        tick();
        chk("trig_state", state, 3);
        chk("trig_count", fifo_count, 3);
        got.delete();
        drain();
        chk("trig_n", got.size(), 3);
        if (got.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("trig_pc", f_pc(got[i]), 8'h10 + i);
            chk("ts_delta_a", 16'(f_ts(got[1]) - f_ts(got[0])), 1);
            chk("ts_delta_b", 16'(f_ts(got[2]) - f_ts(got[1])), 1);
        end

        mode = 2; trig_pc = 8'h20; cap_limit = 0;
        pulse_arm();
        commit(8'h20, 0, 1);
        commit(8'h21, 1, 0); commit(8'h22, 0, 1); commit(8'h23, 2, 0); commit(8'h24, 0, 1);
        chk("filt_state", state, 2);
        chk("filt_count", fifo_count, 3);
        got.delete();
        drain();
        chk("filt_n", got.size(), 3);
        if (got.size() == 3) begin
            chk("filt_pc1", f_pc(got[1]), 8'h22);
            chk("filt_pc2", f_pc(got[2]), 8'h24);
            chk("filt_me1", f_me(got[1]), 1);
            chk("filt_me2", f_me(got[2]), 1);
        end

        do_stop();
        mode = 0; trig_pc = 8'h30;
        pulse_arm();
        for (int i = 0; i < 20; i++) commit(8'h30 + 8'(i), 0, 0);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_drop", drop_cnt, 4);
        got.delete();
        rec_ready = 1;
        commit(8'h50, 0, 0);
        rec_ready = 0;
        chk("fpp_count", fifo_count, 16);
        chk("fpp_drop", drop_cnt, 4);
        drain();
        chk("ovf_n", got.size(), 17);
        if (got.size() == 17) begin
            for (int i = 0; i < 16; i++) chk("ovf_pc", f_pc(got[i]), 8'h30 + i);
            chk("fpp_last", f_pc(got[16]), 8'h50);
        end

        cap_limit = 1; trig_pc = 8'h60;
        do_stop();
        pulse_arm();
        commit(8'h60, 0, 0);
        tick();
        chk("cap1_state", state, 3);
        chk("cap1_count", fifo_count, 1);
        arm = 1; stop = 1; tick(); arm = 0; stop = 0;
        chk("stoparm_state", state, 0);
        chk("stop_noflush", fifo_count, 1);
        drain();

        cap_limit = 0; trig_pc = 8'h70;
        pulse_arm();
        n = 0;
        while (mts != 16'hFFFC && n < 70000) begin tick(); n++; end
        chk("wrap_wait", mts, 16'hFFFC);
        got.delete();
        for (int i = 0; i < 6; i++) commit(8'h70 + 8'(i), 0, 0);
        drain();
        chk("wrap_n", got.size(), 6);
        if (got.size() == 6) begin
            chk("wrap_ts0", f_ts(got[0]), 16'hFFFC);
            chk("wrap_ts3", f_ts(got[3]), 16'hFFFF);
            chk("wrap_ts4", f_ts(got[4]), 16'h0000);
        end

        for (int i = 0; i < 5; i++) commit(8'h80 + 8'(i), 0, 0);
        chk("prerst_count", fifo_count, 5);
        chk("prerst_state", state, 2);
        @(posedge clk); #3 rst = 1; #1;
        chk("arst_state", state, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_valid", rec_valid, 0);
        chk("arst_data", rec_data, 0);
        @(posedge clk); #2 rst = 0;
        got.delete();
        trig_pc = 8'h90;
        pulse_arm();
        commit(8'h90, 0, 0);
        drain();
        chk("post_n", got.size(), 1);
        if (got.size() == 1) chk("post_ts", f_ts(got[0]), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
